// File: rtl/load_align_unit.sv
// Load alignment unit: issues word-aligned reads for RV32I loads, merges two words for
// word-crossing accesses, and returns the sign/zero-extended result with an error code.
module load_align_unit #(
  parameter bit MISALIGN_EN = 1'b1,
  parameter int TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic [1:0]  rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_MISALGN = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic [1:0]         err_q, err_d;
  logic [31:0]        lo_addr;

  function automatic logic is_illegal(input logic [2:0] f);
    return (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
  endfunction

  function automatic logic is_cross(input logic [2:0] f, input logic [1:0] off);
    return ((f == 3'b010) && (off != 2'd0)) ||
           (((f == 3'b001) || (f == 3'b101)) && (off == 2'd3));
  endfunction

  // Shift the little-endian pair right by the byte offset, then extend the low lane.
  function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] off,
                                          input logic [31:0] lo, input logic [31:0] hi);
    logic [31:0] sh;
    sh = 32'({hi, lo} >> {off, 3'b000});
    case (f)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign lo_addr   = {addr_q[31:2], 2'b00};
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign rsp_rd    = rd_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          rd_d     = req_rd;
          cnt_d    = '0;
          if (is_illegal(req_funct3)) begin
            data_d  = 32'h0;
            err_d   = ERR_ILLEGAL;
            state_d = RESP;
          end else if (!MISALIGN_EN && is_cross(req_funct3, req_addr[1:0])) begin
            data_d  = 32'h0;
            err_d   = ERR_MISALGN;
            state_d = RESP;
          end else begin
            state_d = RD0;
          end
        end
      end

      RD0: begin
        mem_req  = 1'b1;
        mem_addr = lo_addr;
        if (mem_ack) begin
          cnt_d = '0;
          if (is_cross(funct3_q, addr_q[1:0])) begin
            lo_d    = mem_rdata;
            state_d = RD1;
          end else begin
            data_d  = extract(funct3_q, addr_q[1:0], mem_rdata, 32'h0);
            err_d   = ERR_OK;
            state_d = RESP;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d  = 32'h0;
          err_d   = ERR_TIMEOUT;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RD1: begin
        mem_req  = 1'b1;
        mem_addr = lo_addr + 32'd4;
        if (mem_ack) begin
          cnt_d   = '0;
          data_d  = extract(funct3_q, addr_q[1:0], lo_q, mem_rdata);
          err_d   = ERR_OK;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d  = 32'h0;
          err_d   = ERR_TIMEOUT;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 32'h0;
      err_q   <= ERR_OK;
      rd_q    <= 5'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Request context and the first word of a split read need no reset.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    funct3_q <= funct3_d;
    lo_q     <= lo_d;
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: directed table, corner sequences and randomized loads
// checked against a byte-level memory model.
module tb_load_align_unit;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, mem_req, mem_ack, rsp_valid, rsp_ready;
  logic [31:0] req_addr, mem_addr, mem_rdata, rsp_data;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd, rsp_rd;
  logic [1:0]  rsp_err;

  logic        v0, rdy0, mreq0, mack0, rv0, rr0;
  logic [31:0] maddr0, rdata0;
  logic [4:0]  rrd0;
  logic [1:0]  rerr0;

  load_align_unit #(.MISALIGN_EN(1'b1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err));

  load_align_unit #(.MISALIGN_EN(1'b0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req(mreq0), .mem_addr(maddr0), .mem_ack(mack0), .mem_rdata(mem_rdata),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_data(rdata0),
    .rsp_rd(rrd0), .rsp_err(rerr0));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed memory, filled with random bytes on first touch.
  bit [7:0] mem_b [bit [31:0]];

  function automatic bit [7:0] gb(input bit [31:0] a);
    if (!mem_b.exists(a)) mem_b[a] = 8'($urandom);
    return mem_b[a];
  endfunction

  function automatic bit [31:0] rdw(input bit [31:0] a);
    return {gb(a + 32'd3), gb(a + 32'd2), gb(a + 32'd1), gb(a)};
  endfunction

  task automatic wrw(input bit [31:0] a, input bit [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[a + 32'(i)] = w[8*i +: 8];
  endtask

  // Reference: assemble the accessed bytes, then account for per-read waits.
  task automatic model(input bit [31:0] a, input bit [2:0] f, input int w0, input int w1,
                       output bit [31:0] d, output bit [1:0] e, output int lat,
                       output int nreq, output int nrd, output bit [31:0] a0,
                       output bit [31:0] a1);
    int size, nr, w;
    d = 0; e = 0; lat = 1; nreq = 0; nrd = 0;
    a0 = a & 32'hFFFF_FFFC;
    a1 = a0 + 32'd4;
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) begin
      e = 2'b01;
      return;
    end
    size = 1 << f[1:0];
    nr = (int'(a[1:0]) + size > 4) ? 2 : 1;
    for (int r = 0; r < nr; r++) begin
      w = (r == 0) ? w0 : w1;
      if (w >= TO) begin
        nreq += TO; lat += TO; e = 2'b11;
        return;
      end
      nreq += w + 1; lat += w + 1; nrd++;
    end
    for (int i = 0; i < size; i++) d |= 32'(gb(a + 32'(i))) << (8 * i);
    if (!f[2] && size == 1) d = {{24{d[7]}}, d[7:0]};
    if (!f[2] && size == 2) d = {{16{d[15]}}, d[15:0]};
  endtask

  logic [31:0] o_data;
  logic [1:0]  o_err;
  logic [4:0]  o_rd;
  int          o_lat, o_nreq;
  bit [31:0]   o_addrs[$];

  task automatic run_load(input bit [31:0] a, input bit [2:0] f, input bit [4:0] rd,
                          input int w0, input int w1, input int hold, input string tag);
    int ridx, wcnt, wlim;
    bit got;
    o_addrs.delete();
    o_nreq = 0; o_lat = 0; got = 0; ridx = 0; wcnt = 0;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_funct3 = f; req_rd = rd;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack = 1'b0;
      if (rsp_valid) begin
        o_lat = c; got = 1;
        break;
      end
      if (mem_req) begin
        o_nreq++;
        wlim = (ridx == 0) ? w0 : w1;
        if (wcnt == wlim) begin
          mem_ack = 1'b1;
          mem_rdata = rdw(mem_addr);
          o_addrs.push_back(mem_addr);
          ridx++; wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
    o_data = rsp_data; o_err = rsp_err; o_rd = rsp_rd;
    if (!got) begin
      total++; bad++;
      $display("FAIL %s.response: got none within 100 cycles, expected rsp_valid", tag);
    end else begin
      rsp_ready = (hold == 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".hold_data"}, rsp_data, o_data);
        chk({tag, ".hold_err"}, 32'(rsp_err), 32'(o_err));
        chk({tag, ".hold_rd"}, 32'(rsp_rd), 32'(o_rd));
        chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        if (i == hold - 1) rsp_ready = 1'b1;
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    end
  endtask

  task automatic chk_res(input string tag, input bit [4:0] rd, input bit [31:0] d,
                         input bit [1:0] e, input int lat, input int nreq, input int nrd,
                         input bit [31:0] a0, input bit [31:0] a1);
    chk({tag, ".data"}, o_data, d);
    chk({tag, ".err"}, 32'(o_err), 32'(e));
    chk({tag, ".rd"}, 32'(o_rd), 32'(rd));
    chk({tag, ".latency"}, 32'(o_lat), 32'(lat));
    chk({tag, ".mem_req_cycles"}, 32'(o_nreq), 32'(nreq));
    chk({tag, ".reads"}, 32'(o_addrs.size()), 32'(nrd));
    if (nrd >= 1 && o_addrs.size() >= 1) chk({tag, ".addr0"}, o_addrs[0], a0);
    if (nrd >= 2 && o_addrs.size() >= 2) chk({tag, ".addr1"}, o_addrs[1], a1);
  endtask

  typedef struct {
    bit [31:0] addr;
    bit [2:0]  f3;
    bit [4:0]  rd;
    int        w0, w1, hold;
    bit [31:0] word0, word1;
    bit [31:0] exp_data;
    bit [1:0]  exp_err;
    int        exp_lat, exp_nreq, exp_nrd;
    bit [31:0] exp_a0, exp_a1;
  } vec_t;

  vec_t tbl[15];

  bit [31:0] m_d, m_a0, m_a1, ra;
  bit [1:0]  m_e;
  int        m_lat, m_nreq, m_nrd, rw0, rw1, rh;
  bit [2:0]  rf;
  bit [4:0]  rrd;

  function automatic int pick_wait();
    int r;
    r = int'($urandom % 16);
    if (r == 0) return TO + int'($urandom % 4);
    if (r == 1) return TO - 1;
    return int'($urandom % 3);
  endfunction

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_funct3 = 3'd0; req_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0; rsp_ready = 1'b0;
    v0 = 1'b0; mack0 = 1'b0; rr0 = 1'b0;

    tbl[0]  = '{32'h0000_1003, 3'd0, 5'd5,  0, 0, 0, 32'h80FF_1234, 32'h0, 32'hFFFF_FF80, 2'b00, 2, 1, 1, 32'h1000, 32'h1004};
    tbl[1]  = '{32'h0000_1003, 3'd4, 5'd6,  0, 0, 0, 32'h80FF_1234, 32'h0, 32'h0000_0080, 2'b00, 2, 1, 1, 32'h1000, 32'h1004};
    tbl[2]  = '{32'h0000_2001, 3'd1, 5'd7,  0, 0, 0, 32'hAB87_65CD, 32'h0, 32'hFFFF_8765, 2'b00, 2, 1, 1, 32'h2000, 32'h2004};
    tbl[3]  = '{32'h0000_3002, 3'd2, 5'd8,  0, 0, 0, 32'h4433_2211, 32'h8877_6655, 32'h6655_4433, 2'b00, 3, 2, 2, 32'h3000, 32'h3004};
    tbl[4]  = '{32'hFFFF_FFFF, 3'd5, 5'd9,  0, 0, 0, 32'hFF00_0000, 32'h0000_0001, 32'h0000_01FF, 2'b00, 3, 2, 2, 32'hFFFF_FFFC, 32'h0};
    tbl[5]  = '{32'h0000_0040, 3'd3, 5'd10, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b01, 1, 0, 0, 32'h40, 32'h44};
    tbl[6]  = '{32'h0000_0041, 3'd6, 5'd11, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b01, 1, 0, 0, 32'h40, 32'h44};
    tbl[7]  = '{32'h0000_0042, 3'd7, 5'd12, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b01, 1, 0, 0, 32'h40, 32'h44};
    tbl[8]  = '{32'h0000_5000, 3'd2, 5'd13, 2, 0, 0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 2'b00, 4, 3, 1, 32'h5000, 32'h5004};
    tbl[9]  = '{32'h0000_6003, 3'd1, 5'd14, 1, 2, 0, 32'h9A00_0000, 32'h0000_00BC, 32'hFFFF_BC9A, 2'b00, 6, 5, 2, 32'h6000, 32'h6004};
    tbl[10] = '{32'h0000_6102, 3'd5, 5'd15, 0, 0, 5, 32'h8001_0000, 32'h0, 32'h0000_8001, 2'b00, 2, 1, 1, 32'h6100, 32'h6104};
    tbl[11] = '{32'h0000_7000, 3'd2, 5'd16, 99, 0, 0, 32'h1111_1111, 32'h0, 32'h0, 2'b11, 17, 16, 0, 32'h7000, 32'h7004};
    tbl[12] = '{32'h0000_7100, 3'd2, 5'd17, 15, 0, 0, 32'h0123_4567, 32'h0, 32'h0123_4567, 2'b00, 17, 16, 1, 32'h7100, 32'h7104};
    tbl[13] = '{32'h0000_7201, 3'd2, 5'd18, 0, 99, 0, 32'h2222_2222, 32'h3333_3333, 32'h0, 2'b11, 18, 17, 1, 32'h7200, 32'h7204};
    tbl[14] = '{32'h0000_7302, 3'd0, 5'd19, 0, 0, 2, 32'h1145_3322, 32'h0, 32'h0000_0045, 2'b00, 2, 1, 1, 32'h7300, 32'h7304};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.mem_addr", mem_addr, 32'h0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_data", rsp_data, 32'h0);
    chk("reset.rsp_rd", 32'(rsp_rd), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      wrw(tbl[i].addr & 32'hFFFF_FFFC, tbl[i].word0);
      wrw((tbl[i].addr & 32'hFFFF_FFFC) + 32'd4, tbl[i].word1);
      run_load(tbl[i].addr, tbl[i].f3, tbl[i].rd, tbl[i].w0, tbl[i].w1, tbl[i].hold,
               $sformatf("vec%0d", i));
      chk_res($sformatf("vec%0d", i), tbl[i].rd, tbl[i].exp_data, tbl[i].exp_err,
              tbl[i].exp_lat, tbl[i].exp_nreq, tbl[i].exp_nrd, tbl[i].exp_a0, tbl[i].exp_a1);
    end

    // Word-crossing load on the instance with splitting disabled.
    @(negedge clk);
    req_addr = 32'h0000_3002; req_funct3 = 3'd2; req_rd = 5'd21;
    chk("noalign.req_ready", 32'(rdy0), 32'd1);
    v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    chk("noalign.mem_req", 32'(mreq0), 32'd0);
    chk("noalign.rsp_valid", 32'(rv0), 32'd1);
    chk("noalign.err", 32'(rerr0), 32'd2);
    chk("noalign.data", rdata0, 32'h0);
    chk("noalign.rd", 32'(rrd0), 32'd21);
    rr0 = 1'b1;
    @(negedge clk);
    rr0 = 1'b0;
    chk("noalign.valid_drop", 32'(rv0), 32'd0);
    chk("noalign.mem_req_after", 32'(mreq0), 32'd0);

    // Stray ack while idle must not start anything.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray_ack.req_ready", 32'(req_ready), 32'd1);

    // Reset while a read is outstanding.
    req_valid = 1'b1; req_addr = 32'h0000_8000; req_funct3 = 3'd2; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_rd0.mem_req", 32'(mem_req), 32'd1);
    chk("rst_rd0.mem_addr", mem_addr, 32'h0000_8000);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd0.mem_req_after", 32'(mem_req), 32'd0);
    chk("rst_rd0.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rd0.req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    for (int n = 0; n < 250; n++) begin
      ra  = ($urandom % 4 == 0) ? 32'hFFFF_FFFC + ($urandom % 4) : $urandom;
      rf  = 3'($urandom % 8);
      rrd = 5'($urandom);
      rw0 = pick_wait();
      rw1 = pick_wait();
      rh  = ($urandom % 4 == 0) ? int'($urandom % 4) : 0;
      model(ra, rf, rw0, rw1, m_d, m_e, m_lat, m_nreq, m_nrd, m_a0, m_a1);
      run_load(ra, rf, rrd, rw0, rw1, rh, $sformatf("rnd%0d", n));
      chk_res($sformatf("rnd%0d", n), rrd, m_d, m_e, m_lat, m_nreq, m_nrd, m_a0, m_a1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
